// File: rtl/alu_result_log.sv
// Result-capture stage behind the lab ALU: synchronised pushbuttons latch the ALU output into an
// accumulator (fed back as operand B) and a circular history buffer that can be stepped for display.
module alu_result_log #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [WIDTH-1:0] alu_in,
  input  logic             capture_n,
  input  logic             clear_n,
  input  logic             view_n,
  output logic [WIDTH-1:0] acc_q,
  output logic             capture_pulse,
  output logic [WIDTH-1:0] hist_q,
  output logic [PW-1:0]    view_idx,
  output logic [PW:0]      hist_count,
  output logic             full
);

  localparam logic [PW:0]   FullCount = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CountOne  = (PW+1)'(1);
  localparam logic [PW-1:0] PtrOne    = PW'(1);

  // Button bit order: [0] capture, [1] clear, [2] view.
  logic [2:0] raw;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] press;

  logic cap, clr, vw, do_cap;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    view_q;
  logic [PW:0]      count_q;
  logic [PW-1:0]    rd_ptr;

  assign raw = {view_n, clear_n, capture_n};

  // While in reset s2/s3 both track s1, so a falling edge that lands inside the reset window is
  // absorbed and never produces a press pulse; released buttons settle to all ones.
  always_ff @(posedge CLOCK_50) begin
    s1_q <= raw;
    s2_q <= s1_q;
    if (!resetn) begin
      s3_q <= s1_q;
    end else begin
      s3_q <= s2_q;
    end
  end

  assign press  = s3_q & ~s2_q;
  assign cap    = press[0];
  assign clr    = press[1];
  assign vw     = press[2];
  assign do_cap = cap & ~clr;

  assign capture_pulse = do_cap;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      acc_q    <= '0;
      wr_ptr_q <= '0;
      view_q   <= '0;
      count_q  <= '0;
    end else begin
      if (clr) begin
        acc_q <= '0;
      end else if (cap) begin
        acc_q <= alu_in;
      end

      if (do_cap) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
        view_q   <= '0;
        if (count_q != FullCount) begin
          count_q <= count_q + CountOne;
        end
      end else if (vw) begin
        if (count_q <= CountOne) begin
          view_q <= '0;
        end else if ({1'b0, view_q} == count_q - CountOne) begin
          view_q <= '0;
        end else begin
          view_q <= view_q + PtrOne;
        end
      end
    end
  end

  // History storage is not reset; stale entries are masked by count_q.
  always_ff @(posedge CLOCK_50) begin
    if (resetn && do_cap) begin
      mem[wr_ptr_q] <= alu_in;
    end
  end

  assign rd_ptr     = wr_ptr_q - PtrOne - view_q;
  assign hist_q     = (count_q != '0) ? mem[rd_ptr] : '0;
  assign view_idx   = view_q;
  assign hist_count = count_q;
  assign full       = (count_q == FullCount);

endmodule
